// File: rtl/i_fetch_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i_fetch_buf_pkg
// Desc     : Shared state encoding and defaults for the i_fetch_buf IF stage.
// Revision : 1.0 - initial release
// ============================================================================
package i_fetch_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int C_PC_INC_DEFAULT = 4;

endpackage : i_fetch_buf_pkg
`default_nettype wire

// File: rtl/i_fetch_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i_fetch_buf_fifo
// Desc     : Power-of-two fetch queue with push, pop, flush, occupancy, head.
// Revision : 1.0 - initial release
// ============================================================================
module i_fetch_buf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = {{(c_ptr_w-1){1'b0}}, 1'b1};
    localparam logic [c_ptr_w:0]   c_cnt_one = {{c_ptr_w{1'b0}}, 1'b1};

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule : i_fetch_buf_fifo
`default_nettype wire

// File: rtl/i_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : i_fetch_buf
// Desc     : IF stage: PC, single-outstanding imem request FSM, fetch queue,
//            IF_ID register with stall and branch-redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module i_fetch_buf
    import i_fetch_buf_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_INC   = C_PC_INC_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_MEM_PCSrc,
    input  logic [ADDR_W-1:0] EX_MEM_NPC,
    input  logic              id_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              IF_ID_valid,
    output logic [DATA_W-1:0] IF_ID_instr,
    output logic [ADDR_W-1:0] IF_ID_npc
);

    localparam int c_cnt_w   = $clog2(DEPTH) + 1;
    localparam int c_entry_w = DATA_W + ADDR_W;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_pc_inc = ADDR_W'(PC_INC);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_pend_npc;
    logic                 r_if_id_valid;
    logic [DATA_W-1:0]    r_if_id_instr;
    logic [ADDR_W-1:0]    r_if_id_npc;

    logic [c_cnt_w-1:0]   w_count;
    logic [c_entry_w-1:0] w_head;
    logic                 w_req;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;

    // A slot is reserved at issue time, so a returning word always fits.
    assign w_req   = !rst && (r_state == ST_IDLE) && (w_count < c_depth);
    assign w_issue = w_req && imem_ack;
    assign w_push  = (r_state == ST_WAIT) && imem_rvalid && !EX_MEM_PCSrc;
    assign w_empty = (w_count == '0);
    assign w_pop   = !EX_MEM_PCSrc && !id_stall && !w_empty;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_issue) w_state_nxt = EX_MEM_PCSrc ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid)       w_state_nxt = ST_IDLE;
                else if (EX_MEM_PCSrc) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (imem_rvalid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_pend_npc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) r_pend_npc <= r_pc + c_pc_inc;
            // Redirect takes precedence over the sequential increment.
            if (EX_MEM_PCSrc) r_pc <= EX_MEM_NPC;
            else if (w_issue) r_pc <= r_pc + c_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= '0;
            r_if_id_npc   <= '0;
        end else if (EX_MEM_PCSrc) begin
            r_if_id_valid <= 1'b0;
        end else if (!id_stall) begin
            r_if_id_valid <= !w_empty;
            if (!w_empty) begin
                r_if_id_instr <= w_head[c_entry_w-1:ADDR_W];
                r_if_id_npc   <= w_head[ADDR_W-1:0];
            end
        end
    end

    i_fetch_buf_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({imem_rdata, r_pend_npc}),
        .i_pop       (w_pop),
        .i_flush     (EX_MEM_PCSrc),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign IF_ID_valid = r_if_id_valid;
    assign IF_ID_instr = r_if_id_instr;
    assign IF_ID_npc   = r_if_id_npc;

endmodule : i_fetch_buf
`default_nettype wire

// File: tb/tb_i_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_i_fetch_buf
// Desc     : Self-checking bench for i_fetch_buf with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i_fetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, pcsrc, stall, ack, rvalid;
    logic [31:0] npc_in, rdata;
    wire         imem_req, if_valid;
    wire  [31:0] imem_addr, if_instr, if_npc;
    wire         wrap_req, wrap_valid;
    wire  [31:0] wrap_addr, wrap_instr, wrap_npc;

    always #5 clk = ~clk;

    i_fetch_buf #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_INC(4), .RESET_PC(32'h0)
    ) u_dut (
        .clk(clk), .rst(rst), .EX_MEM_PCSrc(pcsrc), .EX_MEM_NPC(npc_in),
        .id_stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(ack), .imem_rvalid(rvalid), .imem_rdata(rdata),
        .IF_ID_valid(if_valid), .IF_ID_instr(if_instr), .IF_ID_npc(if_npc)
    );

    i_fetch_buf #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_INC(4), .RESET_PC(32'hFFFF_FFFC)
    ) u_wrap (
        .clk(clk), .rst(rst), .EX_MEM_PCSrc(1'b0), .EX_MEM_NPC(32'h0),
        .id_stall(1'b0), .imem_req(wrap_req), .imem_addr(wrap_addr),
        .imem_ack(1'b1), .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .IF_ID_valid(wrap_valid), .IF_ID_instr(wrap_instr), .IF_ID_npc(wrap_npc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, n_kept = 0, n_cons = 0;
    int          first_rv, first_v;
    bit          ctl_stall = 0, do_redirect = 0, track_first = 0;
    int          ack_pct = 100, lat_min = 2, lat_max = 2;
    logic [31:0] redirect_tgt = 32'h0, first_cons_npc = 32'hDEAD_BEEF;
    bit          os_busy = 0, os_stale = 0;
    logic [31:0] os_addr = 32'h0, pc_m = 32'h0;
    int          os_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic do_reset();
        rst = 1'b1; pcsrc = 1'b0; stall = 1'b0; ack = 1'b0; rvalid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_req",   imem_req,  0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_valid", if_valid,  0);
        check_eq("rst_instr", if_instr,  32'h0);
        check_eq("rst_npc",   if_npc,    32'h0);
        rst = 1'b0;
        exp_q.delete();
        os_busy = 0; os_stale = 0; pc_m = 32'h0; track_first = 0; n_kept = 0;
        #1;
    endtask

    // One clock of the memory model plus the in-order delivery scoreboard.
    task automatic cycle();
        logic rv_now;
        exp_t e;
        stall  = ctl_stall;
        pcsrc  = do_redirect;
        npc_in = redirect_tgt;
        do_redirect = 1'b0;
        ack    = ($urandom_range(0, 99) < ack_pct);
        rv_now = os_busy && (os_cnt == 0);
        rvalid = rv_now;
        rdata  = rv_now ? mem_word(os_addr) : $urandom();
        if (first_rv < 0 && rv_now)  first_rv = cyc;
        if (first_v < 0 && if_valid) first_v  = cyc;

        if (imem_req) check_eq("imem_addr", imem_addr, pc_m);
        if (os_busy)  check_eq("req_while_outstanding", imem_req, 0);

        if (if_valid && !stall && !pcsrc) begin
            n_cons++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", if_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("if_id_instr", if_instr, e.instr);
                check_eq("if_id_npc",   if_npc,   e.npc);
            end
            if (track_first) begin
                first_cons_npc = if_npc;
                track_first = 0;
            end
        end

        if (rv_now) begin
            os_busy = 0;
            if (!os_stale && !pcsrc) begin
                e.instr = mem_word(os_addr);
                e.npc   = os_addr + 32'd4;
                exp_q.push_back(e);
                n_kept++;
            end
        end else if (os_busy) begin
            os_cnt--;
        end

        if (pcsrc) begin
            exp_q.delete();
            os_stale = 1;
        end

        if (imem_req && ack) begin
            os_busy  = 1;
            os_addr  = imem_addr;
            os_stale = pcsrc;
            os_cnt   = $urandom_range(lat_min, lat_max) - 1;
        end

        if (pcsrc)                pc_m = npc_in;
        else if (imem_req && ack) pc_m = pc_m + 32'd4;

        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        bit found;
        int c0;
        rst = 1'b1; pcsrc = 1'b0; stall = 1'b0; ack = 1'b0; rvalid = 1'b0;
        npc_in = 32'h0; rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Streaming with 1-cycle ack, 2-cycle rvalid; also wrap-around instance.
        do_reset();
        check_eq("wrap_first_addr", wrap_addr, 32'hFFFF_FFFC);
        check_eq("wrap_first_req",  wrap_req,  1);
        ctl_stall = 0; ack_pct = 100; lat_min = 2; lat_max = 2;
        first_rv = -1; first_v = -1; c0 = n_cons;
        cycle();
        check_eq("wrap_second_addr", wrap_addr, 32'h0);
        repeat (24) cycle();
        check_eq("t1_latency", first_v - first_rv, 2);
        check_eq("t1_consumed", (n_cons - c0) >= 3, 1);

        // Stall long enough to fill the queue, then release.
        do_reset();
        ctl_stall = 1; ack_pct = 100; lat_min = 2; lat_max = 2;
        repeat (20) cycle();
        check_eq("t2_pushes", n_kept, DEPTH);
        check_eq("t2_req_off", imem_req, 0);
        check_eq("t2_held_invalid", if_valid, 0);
        ctl_stall = 0; ack_pct = 0; c0 = n_cons;
        repeat (8) cycle();
        check_eq("t2_pops", n_cons - c0, DEPTH);

        // Redirect while the request at 0x10 is outstanding.
        do_reset();
        ctl_stall = 0; ack_pct = 100; lat_min = 5; lat_max = 5;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (os_busy && os_addr == 32'h10 && !os_stale) found = 1;
            else cycle();
        end
        check_eq("t3_reached_0x10", found, 1);
        do_redirect = 1; redirect_tgt = 32'h100; track_first = 1;
        first_cons_npc = 32'hDEAD_BEEF;
        cycle();
        check_eq("t3_addr", imem_addr, 32'h100);
        repeat (30) cycle();
        check_eq("t3_first_npc", first_cons_npc, 32'h104);

        // Redirect in the same cycle as rvalid, with a non-empty queue.
        do_reset();
        ctl_stall = 1; ack_pct = 100; lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (n_kept >= 2 && os_busy && os_cnt == 0) found = 1;
            else cycle();
        end
        check_eq("t4_reached", found, 1);
        do_redirect = 1; redirect_tgt = 32'h200;
        cycle();
        check_eq("t4_valid", if_valid, 0);
        check_eq("t4_idle_req", imem_req, 1);
        ctl_stall = 0; ack_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t4_queue_empty", if_valid, 0);
        end

        // Redirect in the same cycle the request is acknowledged.
        do_reset();
        ctl_stall = 0; ack_pct = 0; lat_min = 2; lat_max = 2;
        repeat (2) cycle();
        check_eq("t5_req_pending", imem_req, 1);
        ack_pct = 100; do_redirect = 1; redirect_tgt = 32'h300; track_first = 1;
        first_cons_npc = 32'hDEAD_BEEF;
        cycle();
        check_eq("t5_drain_req", imem_req, 0);
        check_eq("t5_addr", imem_addr, 32'h300);
        repeat (20) cycle();
        check_eq("t5_first_npc", first_cons_npc, 32'h304);

        // Random traffic with a reset in the middle.
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            ctl_stall = ($urandom_range(0, 99) < 30);
            ack_pct   = 60;
            if ($urandom_range(0, 99) < 3) begin
                do_redirect  = 1;
                redirect_tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            cycle();
        end
        ctl_stall = 0; ack_pct = 0;
        repeat (20) cycle();
        check_eq("drain_all_delivered", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_i_fetch_buf
`default_nettype wire
